// File: rtl/mem_mode_sequencer.sv
// Two-button memory-mode stepper: sync, debounce and edge-detect each button,
// then step the mode register with a busy interlock and a one-deep pending slot.
module mem_mode_sequencer #(
  parameter int NUM_MODES       = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int MW = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fwdIn,
  input  logic                 backIn,
  input  logic                 goIdle,
  input  logic                 busy,
  output logic [MW-1:0]        mode,
  output logic [NUM_MODES-1:0] modeOneHot,
  output logic                 write,
  output logic                 read,
  output logic                 modeChanged,
  output logic                 dropped
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [MW-1:0] LAST = MW'(NUM_MODES - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic valid;
    logic dir;
  } req_t;

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CW-1:0]          cnt_q  [2];
  logic [1:0]             deb_q;
  logic [1:0]             deb_d1_q;
  logic [1:0]             press;

  logic [MW-1:0] mode_q, mode_d;
  req_t          pend_q, pend_d;
  req_t          req;
  logic          drop_d;
  logic          chg_q, drop_q;

  assign raw = {backIn, fwdIn};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      deb_q    <= '0;
      deb_d1_q <= '0;
    end else begin
      deb_d1_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (sync_q[i][SYNC_STAGES-1] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CMAX) begin
          cnt_q[i] <= '0;
          deb_q[i] <= ~deb_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign press = deb_q & ~deb_d1_q;

  function automatic logic [MW-1:0] step_fwd(input logic [MW-1:0] m);
    return (m == LAST) ? MW'(1) : m + MW'(1);
  endfunction

  function automatic logic [MW-1:0] step_back(input logic [MW-1:0] m);
    return (m <= MW'(1)) ? LAST : m - MW'(1);
  endfunction

  always_comb begin
    mode_d = mode_q;
    pend_d = pend_q;
    drop_d = 1'b0;
    req    = '0;
    if (goIdle) begin
      mode_d = '0;
      pend_d = '0;
    end else begin
      drop_d = (&press) | (pend_q.valid & (|press));
      if (pend_q.valid) begin
        req = pend_q;
      end else begin
        req.valid = press[0] ^ press[1];
        req.dir   = press[1];
      end
      if (req.valid) begin
        if (busy) begin
          pend_d = req;
        end else begin
          mode_d = req.dir ? step_back(mode_q) : step_fwd(mode_q);
          pend_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= '0;
      pend_q <= '0;
      chg_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pend_q <= pend_d;
      chg_q  <= (mode_d != mode_q);
      drop_q <= drop_d;
    end
  end

  assign mode        = mode_q;
  assign modeOneHot  = NUM_MODES'(1) << mode_q;
  assign write       = (mode_q == MW'(1));
  assign read        = (mode_q == MW'(2));
  assign modeChanged = chg_q;
  assign dropped     = drop_q;

endmodule

// File: tb/tb_mem_mode_sequencer.sv
// Directed bench for mem_mode_sequencer at default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fwdIn = 1'b0;
  logic       backIn = 1'b0;
  logic       goIdle = 1'b0;
  logic       busy = 1'b0;
  logic [1:0] mode;
  logic [2:0] modeOneHot;
  logic       write;
  logic       read;
  logic       modeChanged;
  logic       dropped;

  int vectors = 0;
  int errs = 0;
  int chg_cnt = 0;
  int drop_cnt = 0;

  mem_mode_sequencer dut (
    .clk(clk),
    .reset(reset),
    .fwdIn(fwdIn),
    .backIn(backIn),
    .goIdle(goIdle),
    .busy(busy),
    .mode(mode),
    .modeOneHot(modeOneHot),
    .write(write),
    .read(read),
    .modeChanged(modeChanged),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (modeChanged) chg_cnt++;
    if (dropped) drop_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic hold_fwd(input int n);
    fwdIn = 1'b1;
    tick(n);
    fwdIn = 1'b0;
    tick(12);
  endtask

  task automatic hold_back(input int n);
    backIn = 1'b1;
    tick(n);
    backIn = 1'b0;
    tick(12);
  endtask

  initial begin
    // reset values
    tick(2);
    chk("rst_mode", int'(mode), 0);
    chk("rst_onehot", int'(modeOneHot), 1);
    chk("rst_wr", int'({write, read}), 0);
    chk("rst_pulses", int'({modeChanged, dropped}), 0);
    reset = 1'b0;
    tick(2);

    // 1: held fwd press, latency 7, single step
    fwdIn = 1'b1;
    tick(6);
    chk("t1_mode_e6", int'(mode), 0);
    tick(1);
    chk("t1_mode_e7", int'(mode), 1);
    chk("t1_write", int'(write), 1);
    chk("t1_chg", int'(modeChanged), 1);
    tick(1);
    chk("t1_chg_off", int'(modeChanged), 0);
    tick(12);
    fwdIn = 1'b0;
    tick(12);
    chk("t1_mode_hold", int'(mode), 1);
    chk("t1_chg_cnt", chg_cnt, 1);

    // 2: three more presses, wrap skips 0
    hold_fwd(10);
    chk("t2_mode2", int'(mode), 2);
    chk("t2_read", int'(read), 1);
    chk("t2_onehot2", int'(modeOneHot), 4);
    hold_fwd(10);
    chk("t2_wrap1", int'(mode), 1);
    hold_fwd(10);
    chk("t2_mode2b", int'(mode), 2);
    chk("t2_chg_cnt", chg_cnt, 4);

    // 3: 3-cycle glitch rejected
    fwdIn = 1'b1;
    tick(3);
    fwdIn = 1'b0;
    tick(12);
    chk("t3_mode", int'(mode), 2);
    chk("t3_chg_cnt", chg_cnt, 4);
    chk("t3_drop_cnt", drop_cnt, 0);

    // 4: busy defers back press, fwd while pending is dropped
    busy = 1'b1;
    hold_back(10);
    chk("t4_held", int'(mode), 2);
    hold_fwd(10);
    chk("t4_held2", int'(mode), 2);
    chk("t4_drop_cnt", drop_cnt, 1);
    busy = 1'b0;
    tick(1);
    chk("t4_step", int'(mode), 1);
    chk("t4_chg", int'(modeChanged), 1);
    tick(5);
    chk("t4_cleared", int'(mode), 1);
    chk("t4_chg_cnt", chg_cnt, 5);

    // 5: simultaneous presses dropped; back from 0 goes to 2
    fwdIn = 1'b1;
    backIn = 1'b1;
    tick(10);
    fwdIn = 1'b0;
    backIn = 1'b0;
    tick(12);
    chk("t5_mode", int'(mode), 1);
    chk("t5_drop_cnt", drop_cnt, 2);
    goIdle = 1'b1;
    tick(1);
    goIdle = 1'b0;
    chk("t5_idle", int'(mode), 0);
    chk("t5_idle_chg", int'(modeChanged), 1);
    tick(2);
    hold_back(10);
    chk("t5_back0", int'(mode), 2);
    chk("t5_chg_cnt", chg_cnt, 7);

    // 6: goIdle flushes pending; reset mid-debounce
    busy = 1'b1;
    hold_fwd(10);
    chk("t6_pend_held", int'(mode), 2);
    goIdle = 1'b1;
    tick(1);
    goIdle = 1'b0;
    busy = 1'b0;
    chk("t6_idle", int'(mode), 0);
    chk("t6_onehot", int'(modeOneHot), 1);
    chk("t6_chg", int'(modeChanged), 1);
    chk("t6_nodrop", int'(dropped), 0);
    tick(5);
    chk("t6_pend_lost", int'(mode), 0);
    chk("t6_chg_cnt", chg_cnt, 8);
    goIdle = 1'b1;
    tick(1);
    goIdle = 1'b0;
    chk("t6_idle0_chg", int'(modeChanged), 0);
    fwdIn = 1'b1;
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rst", int'(mode), 0);
    fwdIn = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(15);
    chk("t6_no_step", int'(mode), 0);
    chk("t6_final_chg", chg_cnt, 8);
    chk("t6_final_drop", drop_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
